// File: rtl/pzhsbus_arbiter_pkg.sv
// Shared types and helpers for the pzhsbus round-robin arbiter.
package pzhsbus_arbiter_pkg;

  // IDLE: grant follows the combinational search; LOCKED: grant frozen on lock_index.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arbiter_state_e;

  // Grant index width; a single requester still needs a 1-bit index.
  function automatic int calc_index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pzhsbus_if.sv
// pzhsbus valid/ready/payload channel.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1; once valid is raised the producer holds valid and payload stable
// until that edge, and ready may depend combinationally on valid.
interface pzhsbus_if #(
  parameter int W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/pzhsbus_round_robin_selector.sv
// Combinational round-robin pick: first active request after last_ptr, with wrap.
module pzhsbus_round_robin_selector
  import pzhsbus_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = calc_index_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_ptr_i,
  output logic          grant_valid_o,
  output logic [IW-1:0] grant_index_o
);

  logic [IW-1:0] scan_idx;

  // Scan offsets 1..N from last_ptr; the first hit wins, so last_ptr itself is checked last.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_index_o = '0;
    scan_idx      = '0;
    for (int k = 1; k <= N; k++) begin
      scan_idx = IW'((int'(last_ptr_i) + k) % N);
      if (!grant_valid_o && req_i[scan_idx]) begin
        grant_valid_o = 1'b1;
        grant_index_o = scan_idx;
      end
    end
  end

endmodule

// File: rtl/pzhsbus_arbiter.sv
// Round-robin arbiter: N pzhsbus requesters share one downstream master port.
// The payload path is a zero-latency mux; the grant is frozen while the
// downstream stalls so valid/payload stay tied to one requester.
module pzhsbus_arbiter
  import pzhsbus_arbiter_pkg::*;
#(
  parameter int N           = 2,
  parameter int W           = 8,
  parameter int INDEX_WIDTH = calc_index_width(N)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  pzhsbus_if.slave               slave_if [N],
  pzhsbus_if.master              master_if,
  output logic                   o_grant_valid,
  output logic [INDEX_WIDTH-1:0] o_grant_index,
  output arbiter_state_e         o_dbg_state
);

  localparam int IW = INDEX_WIDTH;

  arbiter_state_e state_q, state_d;
  logic [IW-1:0]  last_ptr_q, last_ptr_d;
  logic [IW-1:0]  lock_index_q, lock_index_d;

  logic [N-1:0]   req_valid;
  logic [W-1:0]   req_payload [N];
  logic           sel_valid;
  logic [IW-1:0]  sel_index;
  logic           grant_valid;
  logic [IW-1:0]  grant_index;
  logic           master_ready;

  // Flatten the requester interfaces and return ready only to the grant holder.
  for (genvar i = 0; i < N; i++) begin : g_slave
    assign req_valid[i]       = slave_if[i].valid;
    assign req_payload[i]     = slave_if[i].payload;
    assign slave_if[i].ready  = master_ready && grant_valid && (grant_index == IW'(i));
  end

  assign master_ready = master_if.ready;

  pzhsbus_round_robin_selector #(
    .N  (N),
    .IW (IW)
  ) u_selector (
    .req_i         (req_valid),
    .last_ptr_i    (last_ptr_q),
    .grant_valid_o (sel_valid),
    .grant_index_o (sel_index)
  );

  // State register; reset abandons any pending transfer immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: lock on a stalled grant, unlock when downstream accepts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_valid && !master_ready) state_d = LOCKED;
      LOCKED:  if (master_ready)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: live search in IDLE, frozen lock_index in LOCKED; index reads 0 without a grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    if (state_q == LOCKED) begin
      grant_valid = req_valid[lock_index_q];
      grant_index = grant_valid ? lock_index_q : '0;
    end else begin
      grant_valid = sel_valid;
      grant_index = sel_valid ? sel_index : '0;
    end
  end

  assign master_if.valid   = grant_valid;
  assign master_if.payload = req_payload[grant_index];
  assign o_grant_valid     = grant_valid;
  assign o_grant_index     = grant_index;
  assign o_dbg_state       = state_q;

  // Pointer/lock bookkeeping: pointer moves only on a completed handshake.
  always_comb begin
    last_ptr_d   = last_ptr_q;
    lock_index_d = lock_index_q;
    if (grant_valid && master_ready) begin
      last_ptr_d = grant_index;
    end
    if (state_q == IDLE && sel_valid && !master_ready) begin
      lock_index_d = sel_index;
    end
  end

  // Bookkeeping registers; last_ptr starts at N-1 so requester 0 is searched first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_ptr_q   <= IW'(N - 1);
      lock_index_q <= '0;
    end else begin
      last_ptr_q   <= last_ptr_d;
      lock_index_q <= lock_index_d;
    end
  end

endmodule

// File: tb/tb_pzhsbus_arbiter.sv
// Bench for pzhsbus_arbiter: an N=4 instance driven with directed vectors and
// an N=1 instance driven as a pass-through.
module tb_pzhsbus_arbiter;
  import pzhsbus_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [3:0] v4 = '0;
  logic       r4 = 1'b0;
  logic [7:0] p4 [4];
  logic [3:0] rdy4;
  logic       v1 = 1'b0;
  logic       r1 = 1'b0;
  logic [7:0] p1 = '0;
  logic       s1_rdy;

  logic           gv4;
  logic [1:0]     gi4;
  arbiter_state_e st4;
  logic           gv1;
  logic [0:0]     gi1;
  arbiter_state_e st1;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  pzhsbus_if #(.W(8)) s4 [4] ();
  pzhsbus_if #(.W(8)) m4 ();
  pzhsbus_if #(.W(8)) s1 [1] ();
  pzhsbus_if #(.W(8)) m1 ();

  for (genvar g = 0; g < 4; g++) begin : g_req4
    assign s4[g].valid   = v4[g];
    assign s4[g].payload = p4[g];
    assign rdy4[g]       = s4[g].ready;
  end
  assign m4.ready      = r4;
  assign s1[0].valid   = v1;
  assign s1[0].payload = p1;
  assign s1_rdy        = s1[0].ready;
  assign m1.ready      = r1;

  pzhsbus_arbiter #(.N(4), .W(8)) dut4 (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .slave_if      (s4),
    .master_if     (m4),
    .o_grant_valid (gv4),
    .o_grant_index (gi4),
    .o_dbg_state   (st4)
  );

  pzhsbus_arbiter #(.N(1), .W(8)) dut1 (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .slave_if      (s1),
    .master_if     (m1),
    .o_grant_valid (gv1),
    .o_grant_index (gi1),
    .o_dbg_state   (st1)
  );

  // A requester must hold valid until its transfer is accepted.
  a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m4.valid && !m4.ready) |=> m4.valid)
    else begin
      errors++;
      $display("FAIL valid_hold: master valid dropped while a transfer was pending");
    end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic [3:0] v, input logic rdy);
    @(posedge clk);
    #1;
    v4 = v;
    r4 = rdy;
  endtask

  task automatic push(input int idx);
    exp_q.push_back({2'(idx), p4[idx]});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && m4.valid && m4.ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hs_unexpected: got transfer from index %0d, expected none", gi4);
      end else begin
        e = exp_q.pop_front();
        check("hs_index", 32'(gi4), 32'(e[9:8]));
        check("hs_payload", 32'(m4.payload), 32'(e[7:0]));
        check("hs_ready_onehot", 32'(rdy4), 32'(4'b0001 << e[9:8]));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int exp_hs;
    int slave_hs;
    int master_hs;
    exp_hs    = 0;
    slave_hs  = 0;
    master_hs = 0;
    p4[0] = 8'h11;
    p4[1] = 8'h22;
    p4[2] = 8'h33;
    p4[3] = 8'h44;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_reset_grant_valid", 32'(gv4), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_grant_valid", 32'(gv4), 32'd0);
    check("rst_master_valid", 32'(m4.valid), 32'd0);
    check("rst_grant_index", 32'(gi4), 32'd0);
    check("rst_ready", 32'(rdy4), 32'd0);
    check("rst_state", 32'(st4), 32'(IDLE));
    check("rst_n1_grant_valid", 32'(gv1), 32'd0);

    // Fairness: all requesting, downstream always ready
    for (int k = 0; k < 6; k++) begin
      drive4(4'hF, 1'b1);
      push(k % 4);
    end
    drive4(4'h0, 1'b0);
    do_reset();

    // Lock: requester 1 stalls for 3 cycles, requester 0 joins and is ignored
    drive4(4'b0110, 1'b0);
    @(negedge clk);
    check("lock_c1_index", 32'(gi4), 32'd1);
    check("lock_c1_valid", 32'(gv4), 32'd1);
    check("lock_c1_payload", 32'(m4.payload), 32'h22);
    check("lock_c1_ready", 32'(rdy4), 32'd0);
    for (int c = 2; c <= 3; c++) begin
      drive4(4'b0111, 1'b0);
      @(negedge clk);
      check("lock_hold_index", 32'(gi4), 32'd1);
      check("lock_hold_payload", 32'(m4.payload), 32'h22);
      check("lock_hold_state", 32'(st4), 32'(LOCKED));
      check("lock_hold_ready", 32'(rdy4), 32'd0);
    end
    drive4(4'b0111, 1'b1);
    push(1);
    @(negedge clk);
    check("lock_c4_index", 32'(gi4), 32'd1);
    drive4(4'b0101, 1'b1);
    push(2);
    @(negedge clk);
    check("lock_c5_index", 32'(gi4), 32'd2);
    check("lock_c5_state", 32'(st4), 32'(IDLE));
    drive4(4'h0, 1'b0);

    // Wrap-around: grant 3, then 0, then 3 back-to-back
    drive4(4'b1000, 1'b1);
    push(3);
    drive4(4'b0001, 1'b1);
    push(0);
    @(negedge clk);
    check("wrap_to0_valid", 32'(gv4), 32'd1);
    drive4(4'b1000, 1'b1);
    push(3);
    @(negedge clk);
    check("wrap_to3_valid", 32'(gv4), 32'd1);
    drive4(4'h0, 1'b0);

    // Mid-transfer reset while locked on requester 2
    drive4(4'b0100, 1'b0);
    drive4(4'b0100, 1'b0);
    @(negedge clk);
    check("mid_locked_state", 32'(st4), 32'(LOCKED));
    check("mid_locked_index", 32'(gi4), 32'd2);
    #1;
    rst_n = 1'b0;
    v4    = 4'h0;
    #1;
    check("mid_reset_state", 32'(st4), 32'(IDLE));
    check("mid_reset_valid", 32'(m4.valid), 32'd0);
    check("mid_reset_index", 32'(gi4), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v4    = 4'hF;
    r4    = 1'b1;
    push(0);
    @(negedge clk);
    check("post_reset_index", 32'(gi4), 32'd0);
    drive4(4'h0, 1'b0);
    @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // N=1 pass-through
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      v1 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      p1 = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("n1_valid", 32'(m1.valid), 32'(v1));
      check("n1_payload", 32'(m1.payload), 32'(p1));
      check("n1_ready", 32'(s1_rdy), 32'(v1 & r1));
      check("n1_grant_valid", 32'(gv1), 32'(v1));
      check("n1_grant_index", 32'(gi1), 32'd0);
      if (v1 && r1) exp_hs++;
      if (v1 && s1_rdy) slave_hs++;
      if (m1.valid && m1.ready) master_hs++;
    end
    check("n1_slave_handshakes", 32'(slave_hs), 32'(exp_hs));
    check("n1_master_handshakes", 32'(master_hs), 32'(exp_hs));

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
